// File: rtl/mdclcg_pkg.sv
// mdclcg_pkg: shared definitions for the dual-CLCG word controller.
//   state_t  - controller state encoding
//   DEF_*    - default parameter values
//   clog2    - ceiling log2 for elaboration-time widths
//   cnt_w    - counter width, never less than one bit
package mdclcg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_WARM    = 3'd3,
    ST_COLLECT = 3'd4
  } state_t;

  localparam int DEF_SEED_W   = 32;
  localparam int DEF_OUT_W    = 32;
  localparam int DEF_WARMUP   = 64;
  localparam int DEF_CORE_LAT = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // A zero-width counter (e.g. WARMUP=0) is not legal, so clamp to 1 bit.
  function automatic int cnt_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mdclcg_word_packer.sv
// mdclcg_word_packer: serial-to-word packer with a one-deep valid/ready
// output register and sticky overflow.
//   clk, rst_n   - clock, async active-low reset
//   clear        - seed accept: wipes partial word, word_valid, overflow
//   collect      - shift zi in this cycle; when low the partial word is dropped
//   zi           - serial bit from the core
//   word_ready   - consumer accepts word_data
//   word_data    - packed word, first collected bit in the MSB
//   word_valid   - word_data holds an unconsumed word
//   overflow     - sticky: a completed word found the register still full
module mdclcg_word_packer
  import mdclcg_pkg::*;
#(
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             collect,
  input  logic             zi,
  input  logic             word_ready,
  output logic [OUT_W-1:0] word_data,
  output logic             word_valid,
  output logic             overflow
);

  localparam int CNT_W = cnt_w(OUT_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);

  logic [OUT_W-1:0] shift_reg;
  logic [OUT_W-1:0] shift_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             word_done;

  // The completing bit is folded in directly so the word transfers on the
  // same edge that samples its last bit.
  assign shift_nxt = {shift_reg[OUT_W-2:0], zi};
  assign word_done = collect && (bit_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else if (clear) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (collect) begin
        shift_reg <= shift_nxt;
        bit_cnt   <= word_done ? '0 : bit_cnt + CNT_W'(1);
      end else begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end

      // A consume and a completion on the same edge keep word_valid high.
      if (word_done) begin
        if (!word_valid || word_ready) begin
          word_data  <= shift_nxt;
          word_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mdclcg_word_ctrl.sv
// mdclcg_word_ctrl: sequencing controller for the modified dual-CLCG core.
// Loads a seed set into the core, skips a warm-up run of Zi bits and packs
// the rest into OUT_W-bit words for a valid/ready consumer.
//   clk, rst_n                 - clock, async active-low reset
//   enable                     - run request; low returns to IDLE
//   cfg_valid/cfg_ready        - seed set handshake, cfg_x0..cfg_q0 seeds
//   core_start                 - one-cycle load pulse to the core
//   core_x0..core_q0           - registered seeds to the core
//   core_zi                    - serial core output
//   word_data/valid/ready      - packed word output handshake
//   busy, warm_done, overflow  - status
//
// state   | meaning
// IDLE    | stopped; re-enable reloads the stored seeds
// LOAD    | core_start high for one cycle
// WAIT    | core latency after the start pulse
// WARM    | discarding WARMUP warm-up bits
// COLLECT | packing Zi into words
module mdclcg_word_ctrl
  import mdclcg_pkg::*;
#(
  parameter int SEED_W   = DEF_SEED_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int WARMUP   = DEF_WARMUP,
  parameter int CORE_LAT = DEF_CORE_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SEED_W-1:0] cfg_x0,
  input  logic [SEED_W-1:0] cfg_y0,
  input  logic [SEED_W-1:0] cfg_p0,
  input  logic [SEED_W-1:0] cfg_q0,
  output logic              core_start,
  output logic [SEED_W-1:0] core_x0,
  output logic [SEED_W-1:0] core_y0,
  output logic [SEED_W-1:0] core_p0,
  output logic [SEED_W-1:0] core_q0,
  input  logic              core_zi,
  output logic [OUT_W-1:0]  word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              warm_done,
  output logic              overflow
);

  localparam int WARM_CW = cnt_w(WARMUP + 1);
  localparam int LAT_CW  = cnt_w(CORE_LAT + 1);

  state_t              state;
  state_t              state_nxt;
  logic [WARM_CW-1:0]  warm_cnt;
  logic [LAT_CW-1:0]   wait_cnt;
  logic                accept;
  logic                collect;

  assign accept  = cfg_valid & cfg_ready;
  assign collect = (state == ST_COLLECT) & enable & ~accept;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (enable) state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = enable ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (!enable)
          state_nxt = ST_IDLE;
        else if (wait_cnt == '0)
          state_nxt = (WARMUP == 0) ? ST_COLLECT : ST_WARM;
      end
      ST_WARM: begin
        if (!enable)
          state_nxt = ST_IDLE;
        else if (warm_cnt == WARM_CW'(1))
          state_nxt = ST_COLLECT;
      end
      ST_COLLECT: if (!enable) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    // A new seed set restarts the sequence from LOAD.
    if (accept) state_nxt = enable ? ST_LOAD : ST_IDLE;
  end

  // Status outputs are registered from the next state so they line up with
  // the state register. cfg_ready therefore reads 0 under reset and rises on
  // the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      core_start <= 1'b0;
      busy       <= 1'b0;
      cfg_ready  <= 1'b0;
      warm_done  <= 1'b0;
      wait_cnt   <= '0;
      warm_cnt   <= '0;
      core_x0    <= '0;
      core_y0    <= '0;
      core_p0    <= '0;
      core_q0    <= '0;
    end else begin
      state      <= state_nxt;
      core_start <= (state_nxt == ST_LOAD);
      busy       <= (state_nxt != ST_IDLE);
      cfg_ready  <= (state_nxt == ST_IDLE) || (state_nxt == ST_WARM) ||
                    (state_nxt == ST_COLLECT);

      if (accept) begin
        core_x0 <= cfg_x0;
        core_y0 <= cfg_y0;
        core_p0 <= cfg_p0;
        core_q0 <= cfg_q0;
      end

      if (state_nxt == ST_LOAD)
        wait_cnt <= LAT_CW'(CORE_LAT - 1);
      else if ((state == ST_WAIT) && (wait_cnt != '0))
        wait_cnt <= wait_cnt - LAT_CW'(1);

      // Reloaded every WAIT cycle so WARM always starts from a full count.
      if (state == ST_WAIT)
        warm_cnt <= WARM_CW'(WARMUP);
      else if (state == ST_WARM)
        warm_cnt <= warm_cnt - WARM_CW'(1);

      if (accept || (state_nxt == ST_LOAD))
        warm_done <= 1'b0;
      else if ((state_nxt == ST_COLLECT) && (state != ST_COLLECT))
        warm_done <= 1'b1;
    end
  end

  mdclcg_word_packer #(
    .OUT_W (OUT_W)
  ) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (accept),
    .collect    (collect),
    .zi         (core_zi),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_valid (word_valid),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_mdclcg_word_ctrl.sv
`timescale 1ns/1ps
// Two controllers (WARMUP=0 and WARMUP=4) share all stimulus; each has its
// own behavioural core and a scoreboard of expected words.
module tb_mdclcg_word_ctrl;

  localparam int SW  = 32;
  localparam int OW  = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic cfg_valid = 1'b0;
  logic word_ready = 1'b0;
  logic [SW-1:0] cfg_x0 = '0, cfg_y0 = '0, cfg_p0 = '0, cfg_q0 = '0;

  logic          zi          [2];
  logic          cfg_ready   [2];
  logic          core_start  [2];
  logic          word_valid  [2];
  logic          busy        [2];
  logic          warm_done   [2];
  logic          overflow    [2];
  logic [SW-1:0] core_x0     [2];
  logic [SW-1:0] core_y0     [2];
  logic [SW-1:0] core_p0     [2];
  logic [SW-1:0] core_q0     [2];
  logic [OW-1:0] word_data   [2];

  always #5 clk = ~clk;

  mdclcg_word_ctrl #(.SEED_W(SW), .OUT_W(OW), .WARMUP(0), .CORE_LAT(LAT)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[0]),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_p0(cfg_p0), .cfg_q0(cfg_q0),
    .core_start(core_start[0]),
    .core_x0(core_x0[0]), .core_y0(core_y0[0]), .core_p0(core_p0[0]), .core_q0(core_q0[0]),
    .core_zi(zi[0]),
    .word_data(word_data[0]), .word_valid(word_valid[0]), .word_ready(word_ready),
    .busy(busy[0]), .warm_done(warm_done[0]), .overflow(overflow[0])
  );

  mdclcg_word_ctrl #(.SEED_W(SW), .OUT_W(OW), .WARMUP(4), .CORE_LAT(LAT)) u_dut_w4 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[1]),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_p0(cfg_p0), .cfg_q0(cfg_q0),
    .core_start(core_start[1]),
    .core_x0(core_x0[1]), .core_y0(core_y0[1]), .core_p0(core_p0[1]), .core_q0(core_q0[1]),
    .core_zi(zi[1]),
    .word_data(word_data[1]), .word_valid(word_valid[1]), .word_ready(word_ready),
    .busy(busy[1]), .warm_done(warm_done[1]), .overflow(overflow[1])
  );

  int n_vec = 0;
  int n_err = 0;

  logic [OW-1:0] exp_q0[$];
  logic [OW-1:0] exp_q1[$];
  int            pos    [2];
  bit            live   [2];
  logic [OW-1:0] acc    [2];
  int            nacc   [2];
  bit            pend   [2];
  bit            ovf    [2];
  bit            wdone  [2];
  logic          cs_prev[2];
  int            starts [2];
  logic [255:0]  rbits;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wu(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic string tg(input string s, input int i);
    return $sformatf("%s_w%0d", s, wu(i));
  endfunction

  // Core stream: the WARMUP=4 core prefixes four junk ones, then both
  // produce 1,0,1,1,0,0,1,0 followed by random bits.
  function automatic logic stream_bit(input int i, input int p);
    logic [7:0] pat;
    int b;
    pat = 8'hB2;
    b = p;
    if (i == 1) begin
      if (p < 4) return 1'b1;
      b = p - 4;
    end
    if (b < 8) return pat[7-b];
    return rbits[b % 256];
  endfunction

  function automatic void push_exp(input int i, input logic [OW-1:0] v);
    if (i == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endfunction

  function automatic int exp_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [OW-1:0] pop_exp(input int i);
    if (i == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic logic [OW-1:0] peek_exp(input int i);
    return (i == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic void clear_model(input int i);
    if (i == 0) exp_q0.delete(); else exp_q1.delete();
    pend[i]  = 1'b0;
    ovf[i]   = 1'b0;
    wdone[i] = 1'b0;
    nacc[i]  = 0;
    acc[i]   = '0;
  endfunction

  // One clock: consume scoreboard entries for handshakes seen before the
  // edge, advance the reference model and core, then compare.
  task automatic tick();
    bit   hs [2];
    bit   ae [2];
    logic zc [2];
    int   pc [2];
    bit   lc [2];
    bit   en_c;
    en_c = enable;
    for (int i = 0; i < 2; i++) begin
      hs[i] = word_valid[i] && word_ready;
      ae[i] = cfg_valid && cfg_ready[i];
      zc[i] = zi[i];
      pc[i] = pos[i];
      lc[i] = live[i];
      if (hs[i]) begin
        check(tg("sb_avail", i), exp_size(i), 1);
        if (exp_size(i) > 0) check(tg("word_data", i), word_data[i], pop_exp(i));
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (ae[i]) begin
        clear_model(i);
      end else begin
        if (hs[i]) pend[i] = 1'b0;
        if (!en_c) begin
          nacc[i] = 0;
        end else if (lc[i] && pc[i] >= wu(i)) begin
          acc[i] = {acc[i][OW-2:0], zc[i]};
          nacc[i]++;
          if (nacc[i] == OW) begin
            nacc[i] = 0;
            if (pend[i]) ovf[i] = 1'b1;
            else begin
              push_exp(i, acc[i]);
              pend[i] = 1'b1;
            end
          end
        end
        if (en_c && lc[i] && pc[i] == wu(i) - 1) wdone[i] = 1'b1;
      end
      if (core_start[i] && !cs_prev[i]) begin
        starts[i]++;
        wdone[i] = 1'b0;
      end
      check(tg("start_width", i), cs_prev[i] & core_start[i], 1'b0);
      if (ae[i] || !en_c) live[i] = 1'b0;
      else if (live[i]) pos[i]++;
      if (cs_prev[i] && !core_start[i]) begin
        live[i] = 1'b1;
        pos[i]  = -LAT;
        nacc[i] = 0;
      end
      cs_prev[i] = core_start[i];
      zi[i] = (live[i] && pos[i] >= 0) ? stream_bit(i, pos[i]) : 1'b0;
      check(tg("word_valid", i), word_valid[i], pend[i]);
      check(tg("overflow", i), overflow[i], ovf[i]);
      check(tg("warm_done", i), warm_done[i], wdone[i]);
      if (pend[i] && exp_size(i) > 0) check(tg("held_data", i), word_data[i], peek_exp(i));
    end
  endtask

  // Ticks following a LOAD-triggering edge: first word timing and contents.
  task automatic run_first_word(input string ph);
    for (int k = 1; k <= 16; k++) begin
      tick();
      for (int i = 0; i < 2; i++) check(tg({ph, "_busy"}, i), busy[i], 1'b1);
      if (k == 5)  check({ph, "_warm_early_w4"}, warm_done[1], 1'b0);
      if (k == 6)  check({ph, "_warm_set_w4"}, warm_done[1], 1'b1);
      if (k == 9)  check({ph, "_early_valid_w0"}, word_valid[0], 1'b0);
      if (k == 10) begin
        check({ph, "_first_valid_w0"}, word_valid[0], 1'b1);
        check({ph, "_first_data_w0"}, word_data[0], 8'hB2);
      end
      if (k == 13) check({ph, "_early_valid_w4"}, word_valid[1], 1'b0);
      if (k == 14) begin
        check({ph, "_first_valid_w4"}, word_valid[1], 1'b1);
        check({ph, "_first_data_w4"}, word_data[1], 8'hB2);
      end
    end
  endtask

  task automatic check_seeds(input string ph, input logic [SW-1:0] x,
                             input logic [SW-1:0] y, input logic [SW-1:0] p,
                             input logic [SW-1:0] q);
    for (int i = 0; i < 2; i++) begin
      check(tg({ph, "_x0"}, i), core_x0[i], x);
      check(tg({ph, "_y0"}, i), core_y0[i], y);
      check(tg({ph, "_p0"}, i), core_p0[i], p);
      check(tg({ph, "_q0"}, i), core_q0[i], q);
    end
  endtask

  task automatic check_all_zero(input string ph);
    for (int i = 0; i < 2; i++) begin
      check(tg({ph, "_start"}, i), core_start[i], 1'b0);
      check(tg({ph, "_busy"}, i), busy[i], 1'b0);
      check(tg({ph, "_cfg_ready"}, i), cfg_ready[i], 1'b0);
      check(tg({ph, "_valid"}, i), word_valid[i], 1'b0);
      check(tg({ph, "_warm"}, i), warm_done[i], 1'b0);
      check(tg({ph, "_ovf"}, i), overflow[i], 1'b0);
      check(tg({ph, "_data"}, i), word_data[i], '0);
      check(tg({ph, "_x0"}, i), core_x0[i], '0);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      clear_model(i);
      live[i]    = 1'b0;
      pos[i]     = 0;
      cs_prev[i] = 1'b0;
      zi[i]      = 1'b0;
    end
  endtask

  initial begin
    int s0, s1;
    rbits = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 2; i++) starts[i] = 0;
    reset_model();

    // Reset state
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      check(tg("idle_cfg_ready", i), cfg_ready[i], 1'b1);
      check(tg("idle_busy", i), busy[i], 1'b0);
    end

    // Seeds 1..4 with enable, streaming consumer
    cfg_x0 = 32'd1; cfg_y0 = 32'd2; cfg_p0 = 32'd3; cfg_q0 = 32'd4;
    cfg_valid = 1'b1; enable = 1'b1; word_ready = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check_seeds("load1", 32'd1, 32'd2, 32'd3, 32'd4);
    for (int i = 0; i < 2; i++) begin
      check(tg("load1_start", i), core_start[i], 1'b1);
      check(tg("load1_starts", i), starts[i], 1);
      check(tg("load1_cfg_ready", i), cfg_ready[i], 1'b0);
    end
    run_first_word("a");
    repeat (10) tick();

    // Consumer stalls across two completions
    word_ready = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < 2; i++) begin
      check(tg("stall_ovf", i), overflow[i], 1'b1);
      check(tg("stall_valid", i), word_valid[i], 1'b1);
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    repeat (3) tick();

    // Random consumer back-pressure
    for (int k = 0; k < 300; k++) begin
      word_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Reseed during COLLECT with a pending word and overflow
    word_ready = 1'b0;
    repeat (20) tick();
    s0 = starts[0]; s1 = starts[1];
    cfg_x0 = 32'd5; cfg_y0 = 32'd6; cfg_p0 = 32'd7; cfg_q0 = 32'd8;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    word_ready = 1'b1;
    check_seeds("reseed", 32'd5, 32'd6, 32'd7, 32'd8);
    for (int i = 0; i < 2; i++) begin
      check(tg("reseed_valid", i), word_valid[i], 1'b0);
      check(tg("reseed_ovf", i), overflow[i], 1'b0);
      check(tg("reseed_start", i), core_start[i], 1'b1);
    end
    check("reseed_starts_w0", starts[0], s0 + 1);
    check("reseed_starts_w4", starts[1], s1 + 1);
    run_first_word("b");
    repeat (5) tick();

    // Disable, then re-enable reloads the retained seeds
    enable = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 2; i++) check(tg("disabled_busy", i), busy[i], 1'b0);
    s0 = starts[0]; s1 = starts[1];
    enable = 1'b1;
    tick();
    check("reenable_starts_w0", starts[0], s0 + 1);
    check("reenable_starts_w4", starts[1], s1 + 1);
    check_seeds("reenable", 32'd5, 32'd6, 32'd7, 32'd8);
    run_first_word("c");
    repeat (7) tick();

    // Asynchronous reset between edges while collecting
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    reset_model();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    s0 = starts[0]; s1 = starts[1];
    repeat (5) tick();
    check("post_rst_nostart_w0", starts[0], s0);
    check("post_rst_nostart_w4", starts[1], s1);
    enable = 1'b1;
    tick();
    check("post_rst_start_w0", starts[0], s0 + 1);
    check("post_rst_start_w4", starts[1], s1 + 1);
    check_seeds("post_rst", '0, '0, '0, '0);
    run_first_word("d");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
